vga_pixel_pipe: RTL

//  Parametrised VGA timing generator and framebuffer read pipeline in one block.

---
 rtl/vga_pixel_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - VGA timing generator with latency-aligned framebuffer read pipeline
module vga_pixel_pipe #(
    parameter int PIX_W   = 3,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CLK_DIV = 2,
    parameter int RD_LAT  = 1,
    parameter int SCALE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             fb_rd,
    output logic [10:0]      fb_x,
    output logic [10:0]      fb_y,
    input  logic [PIX_W-1:0] fb_pixel,
    output logic [PIX_W-1:0] pixel,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de,
    output logic             frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide, so totals beyond 2048 cannot be represented.
    generate
        if (H_TOT > 2048 || V_TOT > 2048 || CLK_DIV < 1 || RD_LAT < 1) begin : g_bad_params
            $error("vga_pixel_pipe: H_TOT/V_TOT must be <= 2048, CLK_DIV and RD_LAT >= 1");
        end
    endgenerate

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // 12-bit boundaries so a boundary of exactly 2048 still compares correctly.
    localparam logic [11:0] H_VIS_C = 12'(H_VIS);
    localparam logic [11:0] H_SS    = 12'(H_VIS + H_FP);
    localparam logic [11:0] H_SE    = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] V_VIS_C = 12'(V_VIS);
    localparam logic [11:0] V_SS    = 12'(V_VIS + V_FP);
    localparam logic [11:0] V_SE    = 12'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOT - 1);

    logic             running;
    logic [DIV_W-1:0] div;
    logic [10:0]      h;
    logic [10:0]      v;
    logic             tick;
    logic             vis;
    logic             hs_act;
    logic             vs_act;
    logic             at_wrap;

    // Delay line entry: {tick, vis, hs_act, vs_act}
    logic [3:0]       dl [RD_LAT];
    logic             dl_busy;
    logic             d_tick;
    logic             d_vis;
    logic             d_hs;
    logic             d_vs;

    assign tick    = running && (div == DIV_LAST);
    assign vis     = ({1'b0, h} < H_VIS_C) && ({1'b0, v} < V_VIS_C);
    assign hs_act  = ({1'b0, h} >= H_SS) && ({1'b0, h} < H_SE);
    assign vs_act  = ({1'b0, v} >= V_SS) && ({1'b0, v} < V_SE);
    assign at_wrap = (h == H_LAST) && (v == V_LAST);

    // Read request is issued in the tick cycle itself; address follows the counters.
    assign fb_rd       = tick && vis;
    assign fb_x        = h >> SCALE;
    assign fb_y        = v >> SCALE;
    assign frame_start = tick && (h == 11'd0) && (v == 11'd0);

    // Run control and pixel-tick divider; stopping only happens at the frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            div     <= '0;
        end else if (!running) begin
            div <= '0;
            if (en) begin
                running <= 1'b1;
            end
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick && at_wrap && !en) begin
                running <= 1'b0;
            end
        end
    end

    // Horizontal/vertical position counters, advanced once per pixel tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
            end else begin
                h <= h + 11'd1;
            end
        end
    end

    // Shift timing flags alongside the framebuffer read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl[i] <= 4'b0000;
            end
        end else begin
            dl[0] <= {tick, vis, hs_act, vs_act};
            for (int i = 1; i < RD_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // Any tick still in flight keeps outputs live after the generator stops.
    always_comb begin
        dl_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            dl_busy = dl_busy | dl[i][3];
        end
    end

    assign d_tick = dl[RD_LAT-1][3];
    assign d_vis  = dl[RD_LAT-1][2];
    assign d_hs   = dl[RD_LAT-1][1];
    assign d_vs   = dl[RD_LAT-1][0];

    // Registered outputs: update on delayed tick, return to idle once stopped and drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel     <= '0;
            de        <= 1'b0;
            hsync_out <= ~HS_POL;
            vsync_out <= ~VS_POL;
        end else if (d_tick) begin
            pixel     <= d_vis ? fb_pixel : '0;
            de        <= d_vis;
            hsync_out <= d_hs ? HS_POL : ~HS_POL;
            vsync_out <= d_vs ? VS_POL : ~VS_POL;
        end else if (!running && !dl_busy) begin
            pixel     <= '0;
            de        <= 1'b0;
            hsync_out <= ~HS_POL;
            vsync_out <= ~VS_POL;
        end
    end

endmodule
